udp_perf_pkt_checker: RTL and testbench

- Receive-side counterpart of the UDP/CMAC performance traffic generator. It sinks the 512-bit AXI-Stream returning from the CMAC loopback path.
- Checks every packet against the generator's deterministic pattern for length, tkeep, payload and sequence number.
- Keeps throughput and error counters that are probed by ILA in the perf-test top.
- Sits in the same clock domain as the generator, the XDMA user clock.

---
 rtl/udp_perf_pkt_checker.sv | 177 +++++++++++++++++
 tb/tb_udp_perf_pkt_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_perf_pkt_checker.sv
// Receive-side checker for the UDP/CMAC perf generator: verifies length, tkeep,
// payload pattern and sequence of every packet and keeps throughput/error counters.
module udp_perf_pkt_checker #(
    parameter int DATA_WIDTH     = 512,
    parameter int KEEP_WIDTH     = 64,
    parameter int CNT_WIDTH      = 32,
    parameter int SEQ_WIDTH      = 16,
    parameter int BEAT_IDX_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [31:0]           pkt_size,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [CNT_WIDTH-1:0]  recv_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  err_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  cycle_cnt,
    output logic                  cycle_cnt_full,
    output logic                  first_pkt_seen,
    output logic [3:0]            err_flags,
    output logic [SEQ_WIDTH-1:0]  expected_seq
);
    localparam int NWORDS = DATA_WIDTH / 32;
    localparam int KW_LOG = $clog2(KEEP_WIDTH);
    localparam int LIW    = 32 - KW_LOG;

    typedef enum logic [1:0] {SOP, BODY, DRAIN} state_t;
    state_t r_state, w_next;

    logic [BEAT_IDX_WIDTH-1:0] r_beat_idx, w_bidx;
    logic [LIW-1:0]            r_last_idx, w_last_idx, w_bidx_ext;
    logic [KW_LOG-1:0]         r_rem_m1, w_rem_m1;
    logic [SEQ_WIDTH-1:0]      r_seq, r_exp_seq, w_seq_cur;
    logic [3:0]                r_pkt_err, r_err_flags, w_beat_err, w_pkt_err;
    logic [CNT_WIDTH-1:0]      r_recv, r_err, r_beat, r_cycle_cnt;
    logic                      r_first;
    logic                      w_acc, w_full, w_in_sop, w_chk_en, w_is_last_exp;
    logic                      w_data_bad, w_keep_bad, w_len_bad, w_seq_bad;
    logic [31:0]               w_size_m1;
    logic [15:0]               w_seq16;
    logic [11:0]               w_b12;
    logic [KEEP_WIDTH-1:0]     w_last_keep, w_exp_keep, w_cmp_mask;
    logic [DATA_WIDTH-1:0]     w_exp_data;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
        return (&x) ? x : x + CNT_WIDTH'(1);
    endfunction

    // Reset is folded in so tready drops the instant RST_N asserts.
    assign s_axis_tready = RST_N & enable & ~clear;
    assign w_acc         = s_axis_tvalid & s_axis_tready;
    assign w_full        = &r_cycle_cnt;

    // Beat-0 parameters come straight off the bus/pkt_size; later beats use latched copies.
    assign w_size_m1  = (pkt_size == 32'd0) ? 32'd0 : pkt_size - 32'd1;
    assign w_last_idx = w_in_sop ? w_size_m1[31:KW_LOG] : r_last_idx;
    assign w_rem_m1   = w_in_sop ? w_size_m1[KW_LOG-1:0] : r_rem_m1;
    assign w_bidx     = w_in_sop ? '0 : r_beat_idx;
    assign w_bidx_ext = LIW'(w_bidx);
    assign w_seq_cur  = w_in_sop ? s_axis_tdata[SEQ_WIDTH-1:0] : r_seq;
    assign w_seq16    = 16'(w_seq_cur);
    assign w_b12      = 12'(w_bidx);

    assign w_is_last_exp = (w_bidx_ext == w_last_idx);

    always_comb begin
        w_exp_data = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (w_bidx == '0 && w == 0) w_exp_data[31:0] = {16'hA5A5, w_seq16};
            else                        w_exp_data[w*32 +: 32] = {w_seq16, w_b12, 4'(w)};
        end
    end

    // rem_m1 of 63 means a full last beat, so "i <= rem_m1" covers both cases.
    always_comb begin
        w_last_keep = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) w_last_keep[i] = (KW_LOG'(i) <= w_rem_m1);
    end

    assign w_exp_keep = w_is_last_exp ? w_last_keep : '1;
    assign w_cmp_mask = s_axis_tlast ? s_axis_tkeep : '1;

    always_comb begin
        w_data_bad = 1'b0;
        for (int i = 0; i < KEEP_WIDTH; i++)
            if (w_cmp_mask[i] && s_axis_tdata[8*i +: 8] != w_exp_data[8*i +: 8]) w_data_bad = 1'b1;
    end

    assign w_keep_bad = (s_axis_tkeep != w_exp_keep);
    assign w_len_bad  = s_axis_tlast ? ~w_is_last_exp : w_is_last_exp;
    assign w_seq_bad  = w_in_sop & r_first & (w_seq_cur != r_exp_seq);
    assign w_beat_err = w_chk_en ? {w_seq_bad, w_len_bad, w_keep_bad, w_data_bad | s_axis_tuser} : 4'd0;
    assign w_pkt_err  = r_pkt_err | w_beat_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     r_state <= SOP;
        else if (clear) r_state <= SOP;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_acc) begin
            case (r_state)
                SOP, BODY: begin
                    if (s_axis_tlast)       w_next = SOP;
                    else if (w_is_last_exp) w_next = DRAIN;
                    else                    w_next = BODY;
                end
                default: if (s_axis_tlast) w_next = SOP;
            endcase
        end
    end

    always_comb begin
        w_in_sop = 1'b0;
        w_chk_en = 1'b0;
        case (r_state)
            SOP:     begin w_in_sop = 1'b1; w_chk_en = 1'b1; end
            BODY:    w_chk_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N || clear) begin
            r_beat_idx  <= '0;
            r_last_idx  <= '0;
            r_rem_m1    <= '0;
            r_seq       <= '0;
            r_exp_seq   <= '0;
            r_pkt_err   <= '0;
            r_err_flags <= '0;
            r_recv      <= '0;
            r_err       <= '0;
            r_beat      <= '0;
            r_cycle_cnt <= '0;
            r_first     <= 1'b0;
        end else begin
            if (w_acc) begin
                r_first <= 1'b1;
                if (w_in_sop) begin
                    r_seq      <= w_seq_cur;
                    r_last_idx <= w_last_idx;
                    r_rem_m1   <= w_rem_m1;
                end
                r_beat_idx <= (w_next == SOP) ? '0 : w_bidx + BEAT_IDX_WIDTH'(1);
                r_pkt_err  <= s_axis_tlast ? 4'd0 : w_pkt_err;
                if (s_axis_tlast) begin
                    r_recv      <= sat_inc(r_recv);
                    if (|w_pkt_err) r_err <= sat_inc(r_err);
                    r_err_flags <= r_err_flags | w_pkt_err;
                    r_exp_seq   <= w_seq_cur + SEQ_WIDTH'(1);
                end
                if (!w_full) r_beat <= sat_inc(r_beat);
            end
            // The first accepted beat's own cycle counts as 1.
            if ((r_first | w_acc) && !w_full) r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
        end
    end

    assign recv_pkt_cnt   = r_recv;
    assign err_pkt_cnt    = r_err;
    assign beat_cnt       = r_beat;
    assign cycle_cnt      = r_cycle_cnt;
    assign cycle_cnt_full = w_full;
    assign first_pkt_seen = r_first;
    assign err_flags      = r_err_flags;
    assign expected_seq   = r_exp_seq;
endmodule

// File: tb/tb_udp_perf_pkt_checker.sv
// Scoreboard bench for udp_perf_pkt_checker: expected per-packet counter state is
// queued by the stimulus and checked by a monitor after every accepted tlast beat.
module tb_udp_perf_pkt_checker;
    localparam int CW = 8;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          CLK = 1'b0, RST_N = 1'b0, enable = 1'b1, clear = 1'b0;
    logic [31:0]   pkt_size = 32'd64;
    logic          s_axis_tvalid = 1'b0, s_axis_tready;
    logic [511:0]  s_axis_tdata = '0;
    logic [63:0]   s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
    logic [CW-1:0] recv_pkt_cnt, err_pkt_cnt, beat_cnt, cycle_cnt;
    logic          cycle_cnt_full, first_pkt_seen;
    logic [3:0]    err_flags;
    logic [15:0]   expected_seq;

    udp_perf_pkt_checker #(.CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .enable(enable), .clear(clear), .pkt_size(pkt_size),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .recv_pkt_cnt(recv_pkt_cnt), .err_pkt_cnt(err_pkt_cnt), .beat_cnt(beat_cnt),
        .cycle_cnt(cycle_cnt), .cycle_cnt_full(cycle_cnt_full),
        .first_pkt_seen(first_pkt_seen), .err_flags(err_flags), .expected_seq(expected_seq)
    );

    always #5 CLK = ~CLK;

    typedef struct { int recv; int err; int flags; int eseq; } exp_t;
    exp_t sbq[$];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mk(input logic [15:0] seq, input int b);
        logic [511:0] d;
        logic [11:0]  bb;
        logic [3:0]   ww;
        d  = '0;
        bb = 12'(b);
        for (int w = 0; w < 16; w++) begin
            ww = 4'(w);
            if (b == 0 && w == 0) d[31:0] = {16'hA5A5, seq};
            else                  d[w*32 +: 32] = {seq, bb, ww};
        end
        return d;
    endfunction

    // Monitor: one cycle after each accepted tlast the counters must match the queued entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            if (RST_N && s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
                @(negedge CLK);
                if (sbq.size() == 0) chk("sb_unexpected_pkt", 64'd1, 64'd0);
                else begin
                    e = sbq.pop_front();
                    chk("recv_pkt_cnt", recv_pkt_cnt, e.recv);
                    chk("err_pkt_cnt",  err_pkt_cnt,  e.err);
                    chk("err_flags",    err_flags,    e.flags);
                    chk("expected_seq", expected_seq, e.eseq);
                end
            end
        end
    end

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k,
                             input logic l, input logic u, input logic hold);
        int t;
        @(negedge CLK);
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k;
        s_axis_tlast = l; s_axis_tuser = u;
        if (hold) begin
            enable = 1'b0;
            repeat (3) begin @(negedge CLK); chk("tready_enable_low", s_axis_tready, 1'b0); end
            enable = 1'b1;
        end
        t = 0;
        while (1) begin
            @(posedge CLK);
            if (s_axis_tready) break;
            t++;
            if (t > 50) begin chk("accept_timeout", 64'd1, 64'd0); break; end
        end
    endtask

    task automatic send_pkt(input logic [15:0] seq, input int nb, input logic [63:0] lk,
                            input int flip_b, input int user_b, input int hold_b, input logic garb,
                            input int er, input int ee, input int ef, input int es);
        logic [511:0] d;
        logic [63:0]  k;
        logic         last;
        for (int b = 0; b < nb; b++) begin
            d = mk(seq, b);
            if (b == flip_b) d[5*32] = ~d[5*32];
            last = (b == nb - 1);
            k = last ? lk : ONES;
            if (last && garb)
                for (int i = 0; i < 64; i++) if (!k[i]) d[i*8 +: 8] = ~d[i*8 +: 8];
            if (last) sbq.push_back(exp_t'{er, ee, ef, es});
            send_beat(d, k, last, b == user_b, b == hold_b);
        end
        @(negedge CLK);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge CLK);
        clear = 1'b1;
        #1 chk("tready_during_clear", s_axis_tready, 1'b0);
        @(negedge CLK);
        clear = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_recv"},  recv_pkt_cnt,   0);
        chk({tag, "_err"},   err_pkt_cnt,    0);
        chk({tag, "_beat"},  beat_cnt,       0);
        chk({tag, "_cycle"}, cycle_cnt,      0);
        chk({tag, "_full"},  cycle_cnt_full, 0);
        chk({tag, "_first"}, first_pkt_seen, 0);
        chk({tag, "_flags"}, err_flags,      0);
        chk({tag, "_eseq"},  expected_seq,   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_tready", s_axis_tready, 1'b0);
        chk_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // 1: good 256-byte packets, one stalled by enable mid-packet
        pkt_size = 32'd256;
        do_clear();
        send_pkt(16'd7,  4, ONES, -1, -1, -1, 1'b0, 1, 0, 0, 8);
        send_pkt(16'd8,  4, ONES, -1, -1, -1, 1'b0, 2, 0, 0, 9);
        send_pkt(16'd9,  4, ONES, -1, -1,  2, 1'b0, 3, 0, 0, 10);
        send_pkt(16'd10, 4, ONES, -1, -1, -1, 1'b0, 4, 0, 0, 11);
        chk("t1_beat_cnt", beat_cnt, 16);
        chk("t1_first_seen", first_pkt_seen, 1'b1);

        // 2: partial last beat with garbage in masked bytes, then wrong last tkeep
        pkt_size = 32'd100;
        do_clear();
        send_pkt(16'h20, 2, 64'h0000_000F_FFFF_FFFF, -1, -1, -1, 1'b1, 1, 0, 0, 'h21);
        send_pkt(16'h21, 2, ONES,                   -1, -1, -1, 1'b0, 2, 1, 2, 'h22);

        // 3: short packet, long packet drained, then a good one
        pkt_size = 32'd192;
        do_clear();
        send_pkt(16'h30, 2, ONES, -1, -1, -1, 1'b0, 1, 1, 4, 'h31);
        send_pkt(16'h31, 5, ONES, -1, -1, -1, 1'b0, 2, 2, 4, 'h32);
        send_pkt(16'h32, 3, ONES, -1, -1, -1, 1'b0, 3, 2, 4, 'h33);
        chk("t3_beat_cnt", beat_cnt, 10);

        // 4: sequence gap with resync, then wrap FFFF -> 0000
        pkt_size = 32'd64;
        do_clear();
        send_pkt(16'd3, 1, ONES, -1, -1, -1, 1'b0, 1, 0, 0, 4);
        send_pkt(16'd4, 1, ONES, -1, -1, -1, 1'b0, 2, 0, 0, 5);
        send_pkt(16'd6, 1, ONES, -1, -1, -1, 1'b0, 3, 1, 8, 7);
        send_pkt(16'd7, 1, ONES, -1, -1, -1, 1'b0, 4, 1, 8, 8);
        do_clear();
        send_pkt(16'hFFFF, 1, ONES, -1, -1, -1, 1'b0, 1, 0, 0, 0);
        send_pkt(16'h0000, 1, ONES, -1, -1, -1, 1'b0, 2, 0, 0, 1);

        // 5: payload bit flip, then tuser error
        pkt_size = 32'd256;
        do_clear();
        send_pkt(16'h50, 4, ONES,  2, -1, -1, 1'b0, 1, 1, 1, 'h51);
        send_pkt(16'h51, 4, ONES, -1,  1, -1, 1'b0, 2, 2, 1, 'h52);

        // 6: cycle counter saturation freezes beat_cnt
        pkt_size = 32'd64;
        do_clear();
        send_pkt(16'd1, 1, ONES, -1, -1, -1, 1'b0, 1, 0, 0, 2);
        repeat (300) @(negedge CLK);
        chk("t6_cycle_sat", cycle_cnt, 255);
        chk("t6_full", cycle_cnt_full, 1'b1);
        send_pkt(16'd2, 1, ONES, -1, -1, -1, 1'b0, 2, 0, 0, 3);
        chk("t6_beat_frozen", beat_cnt, 1);

        // clear mid-packet: the orphan beat becomes a new (bad) packet with seq 16'h0010
        pkt_size = 32'd128;
        send_beat(mk(16'h60, 0), ONES, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        s_axis_tvalid = 1'b0;
        clear = 1'b1;
        #1 chk("t6_tready_clear", s_axis_tready, 1'b0);
        @(negedge CLK);
        clear = 1'b0;
        chk_zero("clear");
        sbq.push_back(exp_t'{1, 1, 5, 'h11});
        send_beat(mk(16'h60, 1), ONES, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        s_axis_tvalid = 1'b0;

        // asynchronous reset drops tready and counters without a clock edge
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_tready", s_axis_tready, 1'b0);
        chk("async_rst_recv", recv_pkt_cnt, 0);
        chk("async_rst_first", first_pkt_seen, 1'b0);
        repeat (2) @(negedge CLK);

        chk("sb_leftover", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
